pattern_generator: RTL and testbench

Stimulus-side companion to the logic analyzer. A host loads up to DEPTH samples into an internal buffer. The block then plays them back onto a parallel output bus at a programmable rate, once or looped, so captures can be driven and checked on-chip. It is the write/drive end of the capture path; the analyzer is the read/sample end.

---
 rtl/pattern_generator.sv | 130 +++++++++++++
 tb/tb_pattern_generator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_generator.sv
// Pattern generator: buffers up to DEPTH host-loaded samples and replays them
// onto pat_out at a programmable rate, once or looped.
module pattern_generator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int DIV_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  input  logic [WIDTH-1:0]         load_data,
  output logic                     load_ready,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic [DIV_W-1:0]         div,
  output logic [WIDTH-1:0]         pat_out,
  output logic                     pat_strobe,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    idx, idx_next, count_next;
  logic [DIV_W-1:0] tick, tick_next, div_lat, div_lat_next;
  logic             loop_lat, loop_lat_next;
  logic [WIDTH-1:0] pat_next;
  logic             strobe_next, done_next;
  logic             load_fire;

  logic [WIDTH-1:0] mem [DEPTH];

  assign load_ready = (state == IDLE) && (count < CW'(DEPTH));
  assign load_fire  = load_valid && load_ready;

  // Buffer storage has no reset; entries at or above count are never read.
  always_ff @(posedge clk) begin
    if (load_fire && !clear)
      mem[count[AW-1:0]] <= load_data;
  end

  always_comb begin
    state_next    = state;
    count_next    = count;
    idx_next      = idx;
    tick_next     = tick;
    div_lat_next  = div_lat;
    loop_lat_next = loop_lat;
    pat_next      = pat_out;
    strobe_next   = 1'b0;
    done_next     = 1'b0;

    case (state)
      IDLE: begin
        if (clear)
          count_next = '0;
        else if (load_fire)
          count_next = count + 1'b1;

        if (start && (count != '0)) begin
          state_next    = RUN;
          pat_next      = mem[0];
          strobe_next   = 1'b1;
          idx_next      = CW'(1);
          tick_next     = div;
          div_lat_next  = div;
          loop_lat_next = loop;
        end
      end

      RUN: begin
        // stop wins over every form of advance; pat_out keeps its value.
        if (stop) begin
          state_next = IDLE;
        end else if (tick != '0) begin
          tick_next = tick - 1'b1;
        end else if (idx < count) begin
          pat_next    = mem[idx[AW-1:0]];
          strobe_next = 1'b1;
          idx_next    = idx + 1'b1;
          tick_next   = div_lat;
        end else if (loop_lat) begin
          pat_next    = mem[0];
          strobe_next = 1'b1;
          idx_next    = CW'(1);
          tick_next   = div_lat;
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      idx        <= '0;
      tick       <= '0;
      div_lat    <= '0;
      loop_lat   <= 1'b0;
      pat_out    <= '0;
      pat_strobe <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      idx        <= idx_next;
      tick       <= tick_next;
      div_lat    <= div_lat_next;
      loop_lat   <= loop_lat_next;
      pat_out    <= pat_next;
      pat_strobe <= strobe_next;
      done       <= done_next;
      busy       <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator: an expected-trace model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pattern_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       clear, start, stop, loop;
  logic [7:0] div;
  logic [7:0] pat_out;
  logic       pat_strobe, busy, done;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  pattern_generator #(.WIDTH(8), .DEPTH(16), .DIV_W(8)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .clear(clear), .start(start), .stop(stop), .loop(loop), .div(div),
    .pat_out(pat_out), .pat_strobe(pat_strobe), .busy(busy), .done(done),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: buffer contents as a queue; a run is a precomputed list of
  // per-cycle output states consumed one per clock edge.
  typedef struct {
    logic [7:0] pat;
    logic       strobe;
    logic       busy;
    logic       done;
  } ent_t;

  logic [7:0] m_mem[$];
  ent_t       trace[$];
  logic [7:0] m_pat;
  logic       m_strobe, m_busy, m_done, m_loop;
  int         m_div;

  function automatic void gen_pass();
    foreach (m_mem[k]) begin
      trace.push_back('{m_mem[k], 1'b1, 1'b1, 1'b0});
      for (int j = 0; j < m_div; j++)
        trace.push_back('{m_mem[k], 1'b0, 1'b1, 1'b0});
    end
    if (!m_loop)
      trace.push_back('{m_mem[m_mem.size()-1], 1'b0, 1'b0, 1'b1});
  endfunction

  function automatic void apply_next();
    ent_t e;
    e = trace.pop_front();
    m_pat = e.pat; m_strobe = e.strobe; m_busy = e.busy; m_done = e.done;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mem.delete(); trace.delete();
      m_pat = 8'h00; m_strobe = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      m_loop = 1'b0; m_div = 0;
    end else if (m_busy) begin
      if (stop) begin
        trace.delete();
        m_busy = 1'b0; m_strobe = 1'b0; m_done = 1'b0;
      end else begin
        if (trace.size() == 0) gen_pass();
        apply_next();
      end
    end else begin
      int n0;
      n0 = m_mem.size();
      m_strobe = 1'b0; m_done = 1'b0;
      if (clear) m_mem.delete();
      else if (load_valid && m_mem.size() < 16) m_mem.push_back(load_data);
      if (start && n0 > 0) begin
        m_loop = loop; m_div = int'(div);
        trace.delete();
        gen_pass();
        apply_next();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pat_out", 32'(pat_out), 32'(m_pat));
      chk("pat_strobe", 32'(pat_strobe), 32'(m_strobe));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("count", 32'(count), 32'(m_mem.size()));
      chk("load_ready", 32'(load_ready), 32'(!m_busy && m_mem.size() < 16));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [7:0] d);
    load_valid = 1'b1; load_data = d; step(); load_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp3 [3];
    exp3[0] = 8'hA5; exp3[1] = 8'h3C; exp3[2] = 8'hF0;
    rst = 1'b1; load_valid = 1'b0; load_data = 8'h00;
    clear = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; div = 8'd0;
    step(); step();
    chk("rst_pat", 32'(pat_out), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    // Three samples, div=0, one-shot
    load(8'hA5); load(8'h3C); load(8'hF0);
    chk("t1_count", 32'(count), 32'd3);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t1_pat", 32'(pat_out), 32'(exp3[i]));
      chk("t1_strobe", 32'(pat_strobe), 32'h1);
      chk("t1_busy", 32'(busy), 32'h1);
      if (i < 2) step();
    end
    step();
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_busy_low", 32'(busy), 32'h0);
    chk("t1_hold", 32'(pat_out), 32'hF0);
    step();
    chk("t1_done_pulse", 32'(done), 32'h0);
    chk("t1_hold2", 32'(pat_out), 32'hF0);

    // Same samples, div=2
    div = 8'd2; start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("t2_pat", 32'(pat_out), 32'(exp3[i/3]));
      chk("t2_strobe", 32'(pat_strobe), 32'(i % 3 == 0));
      chk("t2_busy", 32'(busy), 32'h1);
      step();
    end
    chk("t2_done", 32'(done), 32'h1);
    stop = 1'b1; step(); stop = 1'b0;    // stop while idle does nothing
    chk("t2_idle_stop", 32'(count), 32'd3);

    // Overfill: 17 offers, only 16 stored
    clear = 1'b1; step(); clear = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      load_data = 8'(i); step();
    end
    load_valid = 1'b0;
    chk("t3_full_count", 32'(count), 32'd16);
    chk("t3_full_ready", 32'(load_ready), 32'h0);
    div = 8'd0; start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t3_pat", 32'(pat_out), 32'(i));
      step();
    end
    chk("t3_done", 32'(done), 32'h1);
    chk("t3_last", 32'(pat_out), 32'h0F);
    clear = 1'b1; step(); clear = 1'b0;
    chk("t3_clear_count", 32'(count), 32'd0);
    chk("t3_clear_ready", 32'(load_ready), 32'h1);

    // Looping then stop
    load(8'h11); load(8'h22);
    loop = 1'b1; start = 1'b1; step(); start = 1'b0; loop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_pat", 32'(pat_out), (i % 2 == 0) ? 32'h11 : 32'h22);
      chk("t4_nodone", 32'(done), 32'h0);
      if (i < 4) step();
    end
    step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("t4_stop_busy", 32'(busy), 32'h0);
    chk("t4_stop_done", 32'(done), 32'h0);
    chk("t4_stop_hold", 32'(pat_out), 32'h22);
    step();
    chk("t4_after_done", 32'(done), 32'h0);

    // Empty start ignored; loads/clear/start ignored during a run
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("t5_empty_busy", 32'(busy), 32'h0);
    step();
    chk("t5_empty_done", 32'(done), 32'h0);
    load(8'h5A); load(8'hC3);
    div = 8'd3; start = 1'b1; step(); start = 1'b0;
    load_valid = 1'b1; load_data = 8'h99; clear = 1'b1; start = 1'b1;
    div = 8'd0; loop = 1'b1;
    chk("t5_run_ready", 32'(load_ready), 32'h0);
    step();
    load_valid = 1'b0; clear = 1'b0; start = 1'b0; loop = 1'b0;
    chk("t5_run_count", 32'(count), 32'd2);
    repeat (6) step();
    chk("t5_second", 32'(pat_out), 32'hC3);
    step();
    chk("t5_done", 32'(done), 32'h1);

    // Asynchronous reset mid-run
    div = 8'd3; start = 1'b1; step(); start = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("t6_async_pat", 32'(pat_out), 32'h00);
    chk("t6_async_busy", 32'(busy), 32'h0);
    chk("t6_async_count", 32'(count), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("t6_start_ignored", 32'(busy), 32'h0);
    step();
    chk("t6_no_done", 32'(done), 32'h0);
    step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
